// File: rtl/irq_ctrl.sv
// irq_ctrl: programmable interrupt controller on the system bridge.
// Latches peripheral requests into PEND, masks them, raises the CPU
// interrupt for the highest-priority (lowest index) eligible source and
// sequences each interrupt as raise -> claim -> end-of-interrupt.
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   src[N_SRC]     raw interrupt requests, synchronous to clk
//   sel, we        bridge slave select and write enable
//   addr[4]        byte offset, [3:2] selects PEND/MASK/EDGE/CLAIM
//   wdata[32]      write data
//   rdata[32]      combinational read data
//   irq            registered interrupt request to the CPU
//   hwint[N_SRC]   registered one-hot of the raised or serviced source
module irq_ctrl #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             sel,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq,
  output logic [N_SRC-1:0] hwint
);

  localparam int unsigned IDW = 4;

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_MASK  = 2'd1;
  localparam logic [1:0] A_EDGE  = 2'd2;
  localparam logic [1:0] A_CLAIM = 2'd3;

  typedef enum logic [1:0] {IDLE, ASSERT, INSVC} state_t;

  state_t           state;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edge_sel;
  logic [N_SRC-1:0] s_q;
  logic [IDW-1:0]   svc_id;

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] best_oh;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] pend_nxt;
  logic [IDW-1:0]   best;
  logic             any_elig;
  logic             claim_ok;
  logic             claim;
  logic             eoi;
  logic             wr_pend;
  logic             wr_mask;
  logic             wr_edge;
  logic             unused_bits;

  assign elig     = pend & mask;
  assign any_elig = |elig;

  // Lowest set index of elig wins; scanning downward leaves the lowest last.
  always_comb begin
    best = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (elig[i]) best = IDW'(i);
    end
  end

  assign best_oh = N_SRC'(any_elig) << best;

  // A claim is only meaningful while something is actually eligible.
  assign claim_ok = (state == ASSERT) && any_elig;
  assign claim    = sel && !we && (addr[3:2] == A_CLAIM) && claim_ok;
  assign eoi      = sel && we && (addr[3:2] == A_CLAIM) && (state == INSVC) &&
                    (wdata[IDW-1:0] == svc_id);
  assign wr_pend  = sel && we && (addr[3:2] == A_PEND);
  assign wr_mask  = sel && we && (addr[3:2] == A_MASK);
  assign wr_edge  = sel && we && (addr[3:2] == A_EDGE);

  // New requests are OR-ed in last so they win over W1C and claim clears.
  assign set_vec  = (edge_sel & src & ~s_q) | (~edge_sel & src);
  assign clr_vec  = (wr_pend ? wdata[N_SRC-1:0] : '0) | (claim ? best_oh : '0);
  assign pend_nxt = (pend & ~clr_vec) | set_vec;

  // Register read mux.
  always_comb begin
    rdata = '0;
    case (addr[3:2])
      A_PEND:  rdata = 32'(pend);
      A_MASK:  rdata = 32'(mask);
      A_EDGE:  rdata = 32'(edge_sel);
      A_CLAIM: rdata = claim_ok ? {1'b1, 27'b0, best} : 32'h0;
      default: rdata = '0;
    endcase
  end

  assign unused_bits = ^{addr[1:0], wdata};

  // Registers and raise/claim/EOI sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      mask     <= '0;
      edge_sel <= '0;
      s_q      <= '0;
      svc_id   <= '0;
      irq      <= 1'b0;
      hwint    <= '0;
    end else begin
      pend <= pend_nxt;
      s_q  <= src;
      if (wr_mask) mask     <= wdata[N_SRC-1:0];
      if (wr_edge) edge_sel <= wdata[N_SRC-1:0];
      case (state)
        IDLE: begin
          if (any_elig) begin
            state <= ASSERT;
            irq   <= 1'b1;
            hwint <= best_oh;
          end
        end
        ASSERT: begin
          if (claim) begin
            state  <= INSVC;
            svc_id <= best;
            irq    <= 1'b0;
            hwint  <= best_oh;
          end else if (!any_elig) begin
            state <= IDLE;
            irq   <= 1'b0;
            hwint <= '0;
          end else begin
            // Follow the current winner so a higher priority preempts.
            hwint <= best_oh;
          end
        end
        INSVC: begin
          irq <= 1'b0;
          if (eoi) begin
            state <= IDLE;
            hwint <= '0;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
          hwint <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic for irq_ctrl,
// checked every cycle against a behavioural model of the controller.
module tb_irq_ctrl;

  localparam int unsigned N = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  src = '0;
  logic          sel = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          irq;
  logic [N-1:0]  hwint;

  int n_checks = 0;
  int n_fail = 0;

  irq_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .reset(reset), .src(src), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq), .hwint(hwint)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing raised, 1 = raised to the CPU, 2 = being serviced
  logic [N-1:0] m_pend = '0, m_mask = '0, m_edge = '0, m_sq = '0, m_hw = '0;
  logic         m_irq = 1'b0;
  int           m_phase = 0;
  int           m_svc = 0;

  function automatic int pick(input logic [N-1:0] e);
    for (int i = 0; i < int'(N); i++) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    int b;
    b = pick(m_pend & m_mask);
    case (a[3:2])
      2'd0: return 32'(m_pend);
      2'd1: return 32'(m_mask);
      2'd2: return 32'(m_edge);
      default: return (m_phase == 1 && b >= 0) ? (32'h8000_0000 | 32'(b)) : 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int b;
    bit is_claim, is_eoi, is_w1c;
    logic [N-1:0] np;
    if (reset) begin
      m_pend <= '0; m_mask <= '0; m_edge <= '0; m_sq <= '0;
      m_hw <= '0; m_irq <= 1'b0; m_phase <= 0; m_svc <= 0;
    end else begin
      b        = pick(m_pend & m_mask);
      is_claim = sel && !we && addr[3:2] == 2'd3 && m_phase == 1 && b >= 0;
      is_eoi   = sel && we && addr[3:2] == 2'd3 && m_phase == 2 &&
                 int'(wdata[3:0]) == m_svc;
      is_w1c   = sel && we && addr[3:2] == 2'd0;
      for (int i = 0; i < int'(N); i++) begin
        bit req, drop;
        req   = m_edge[i] ? (src[i] && !m_sq[i]) : src[i];
        drop  = (is_w1c && wdata[i]) || (is_claim && i == b);
        np[i] = req || (m_pend[i] && !drop);
      end
      m_pend <= np;
      m_sq   <= src;
      if (sel && we && addr[3:2] == 2'd1) m_mask <= wdata[N-1:0];
      if (sel && we && addr[3:2] == 2'd2) m_edge <= wdata[N-1:0];
      if (m_phase == 0 && b >= 0) begin
        m_phase <= 1; m_irq <= 1'b1; m_hw <= N'(1) << b;
      end else if (m_phase == 1) begin
        if (is_claim) begin
          m_phase <= 2; m_svc <= b; m_irq <= 1'b0; m_hw <= N'(1) << b;
        end else if (b < 0) begin
          m_phase <= 0; m_irq <= 1'b0; m_hw <= '0;
        end else begin
          m_hw <= N'(1) << b;
        end
      end else if (m_phase == 2 && is_eoi) begin
        m_phase <= 0; m_hw <= '0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model; inputs change at posedge+2.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_irq", 32'(irq), 32'(m_irq));
      chk("cmp_hwint", 32'(hwint), 32'(m_hw));
      chk("cmp_rdata", rdata, m_read(addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(name, rdata, exp);
    tick();
    sel = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src = '0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_hwint", 32'(hwint), 32'h0);

    // 1: single edge pulse on src[2]
    wr(4'h4, 32'h3F); wr(4'h8, 32'h3F);
    src = 6'h04; tick(); src = '0;
    chk("t1_irq_early", 32'(irq), 32'h0);
    rd(4'h0, 32'h04, "t1_pend");
    chk("t1_irq", 32'(irq), 32'h1);
    chk("t1_hwint", 32'(hwint), 32'h04);

    // 2: preemption by src[1] before claim
    do_reset();
    wr(4'h4, 32'h3F); wr(4'h8, 32'h3F);
    src = 6'h10; tick(); src = 6'h02; tick(); src = '0;
    chk("t2_hw_first", 32'(hwint), 32'h10);
    tick();
    chk("t2_hw_preempt", 32'(hwint), 32'h02);
    rd(4'hC, 32'h8000_0001, "t2_claim");
    chk("t2_irq_claimed", 32'(irq), 32'h0);
    rd(4'h0, 32'h10, "t2_pend");

    // 3: wrong-id EOI ignored, correct EOI re-raises source 4
    wr(4'hC, 32'h3);
    chk("t3_bad_eoi_irq", 32'(irq), 32'h0);
    chk("t3_bad_eoi_hw", 32'(hwint), 32'h02);
    wr(4'hC, 32'h1);
    chk("t3_eoi_hw", 32'(hwint), 32'h0);
    tick();
    chk("t3_reraise_irq", 32'(irq), 32'h1);
    chk("t3_reraise_hw", 32'(hwint), 32'h10);

    // 4: level source held through claim and EOI
    do_reset();
    wr(4'h4, 32'h3F); wr(4'h8, 32'h0);
    src = 6'h01; tick(); tick();
    chk("t4_irq", 32'(irq), 32'h1);
    rd(4'hC, 32'h8000_0000, "t4_claim");
    rd(4'h0, 32'h01, "t4_pend_kept");
    wr(4'hC, 32'h0);
    chk("t4_eoi_irq", 32'(irq), 32'h0);
    tick();
    chk("t4_reraise", 32'(irq), 32'h1);
    src = '0;

    // 5: masked pending, then unmask, then W1C
    do_reset();
    wr(4'h4, 32'h0); wr(4'h8, 32'h3F);
    src = 6'h08; tick(); src = '0;
    rd(4'h0, 32'h08, "t5_pend");
    chk("t5_masked_irq", 32'(irq), 32'h0);
    wr(4'h4, 32'h08); tick();
    chk("t5_unmask_irq", 32'(irq), 32'h1);
    chk("t5_unmask_hw", 32'(hwint), 32'h08);
    wr(4'h0, 32'h08); tick();
    chk("t5_w1c_irq", 32'(irq), 32'h0);
    rd(4'h0, 32'h0, "t5_pend_clr");

    // 6: asynchronous reset mid-service
    do_reset();
    wr(4'h4, 32'h3F); wr(4'h8, 32'h3F);
    src = 6'h02; tick(); src = '0; tick();
    rd(4'hC, 32'h8000_0001, "t6_claim");
    #1 reset = 1'b1;
    #1;
    chk("t6_irq", 32'(irq), 32'h0);
    chk("t6_hwint", 32'(hwint), 32'h0);
    addr = 4'h0; #1; chk("t6_pend", rdata, 32'h0);
    addr = 4'h4; #1; chk("t6_mask", rdata, 32'h0);
    reset = 1'b0;
    tick();
    rd(4'hC, 32'h0, "t6_claim_after");

    // Randomized traffic against the model.
    do_reset();
    wr(4'h4, 32'h3F);
    for (int c = 0; c < 4000; c++) begin
      int r;
      src = N'($urandom & $urandom & $urandom);
      r = int'($urandom_range(0, 11));
      sel = 1'b0; we = 1'b0;
      case (r)
        0: begin sel = 1'b1; we = 1'b1; addr = 4'h0; wdata = $urandom; end
        1: begin sel = 1'b1; we = 1'b1; addr = 4'h4;
                 wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3F; end
        2: begin sel = 1'b1; we = 1'b1; addr = 4'h8; wdata = $urandom; end
        3, 4: begin sel = 1'b1; addr = 4'hC; end
        5, 6: begin sel = 1'b1; we = 1'b1; addr = 4'hC;
                 wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'(m_svc); end
        7: begin sel = 1'b1; addr = 4'($urandom); end
        default: begin addr = 4'($urandom); wdata = $urandom; end
      endcase
      if (c % 997 == 996) do_reset();
      else tick();
    end
    sel = 1'b0; we = 1'b0; src = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
